// File: rtl/seg14_scan_sched.sv
// -----------------------------------------------------------------------------
// seg14_scan_sched
//
// Scan scheduler for a multiplexed 14-segment display. It holds a 16-entry
// host-writable message buffer of character codes. It time-slices the shared
// sel/segm lines across NUM_DIGITS digits, with a blanking gap between digits
// to prevent ghosting. It can also rotate (scroll) the message across the
// display.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   rst_n      : synchronous, active-low reset
//   wr_en      : buffer write request, held by the host until accepted
//   wr_addr    : buffer entry index
//   wr_data    : character code (0-9 digits, 10-35 A-Z, 36 space, 37-63 blank)
//   wr_ready   : high in every BLANK cycle; a write lands when wr_en && wr_ready
//   msg_len    : active message length 0..16 (larger values clamp to 16)
//   scroll_en  : rotate the message by one character every SCROLL_DIV frames
//   sel        : one-hot digit select, all zero during the blanking gap
//   segm       : glyph for the selected digit (MSB = segment a)
//   frame_done : one-cycle pulse during the last DRIVE cycle of the last digit
//
// Optional build macro SEG14_BLINK_EN:
//   Adds input blink_mask[NUM_DIGITS-1:0]. A blink phase toggles every 32
//   frames. While the phase is 1, masked digits drive segm=0. sel keeps
//   scanning as normal.
//
// Timing model: state_r names the phase that the next clock edge presents on
// the registered outputs. The first edge after reset therefore shows a BLANK
// cycle with wr_ready=1. The following edge shows digit 0.
// -----------------------------------------------------------------------------
module seg14_scan_sched #(
  parameter int NUM_DIGITS   = 12,
  parameter int BUF_DEPTH    = 16,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int SCROLL_DIV   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [5:0]            wr_data,
  output logic                  wr_ready,
  input  logic [4:0]            msg_len,
  input  logic                  scroll_en,
`ifdef SEG14_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [NUM_DIGITS-1:0] sel,
  output logic [13:0]           segm,
  output logic                  frame_done
);

  localparam int DGW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int DWW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BKW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int FCW = (SCROLL_DIV > 1)   ? $clog2(SCROLL_DIV)   : 1;

  localparam logic [DGW-1:0]        DIGIT_LAST = DGW'(NUM_DIGITS - 1);
  localparam logic [DWW-1:0]        DWELL_LAST = DWW'(DWELL_CYCLES - 1);
  localparam logic [BKW-1:0]        BLANK_LAST = BKW'(BLANK_CYCLES - 1);
  localparam logic [FCW-1:0]        FRAME_LAST = FCW'(SCROLL_DIV - 1);
  localparam logic [4:0]            LEN_MAX    = 5'(BUF_DEPTH);
  localparam logic [5:0]            CODE_SPACE = 6'd36;
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Character code to 14-segment glyph. Bit order is a b c d e f g1 g2 h i j k l m.
  function automatic logic [13:0] seg14_glyph(input logic [5:0] code);
    logic [13:0] g;
    case (code)
      6'd0:    g = 14'b11111100_001001;
      6'd1:    g = 14'b01100000_001000;
      6'd2:    g = 14'b11011011_000000;
      6'd3:    g = 14'b11110001_000000;
      6'd4:    g = 14'b01100111_000000;
      6'd5:    g = 14'b10110111_000000;
      6'd6:    g = 14'b10111111_000000;
      6'd7:    g = 14'b11100000_000000;
      6'd8:    g = 14'b11111111_000000;
      6'd9:    g = 14'b11110111_000000;
      6'd10:   g = 14'b11101111_000000;
      6'd11:   g = 14'b11110001_010010;
      6'd12:   g = 14'b10011100_000000;
      6'd13:   g = 14'b11110000_010010;
      6'd14:   g = 14'b10011110_000000;
      6'd15:   g = 14'b10001110_000000;
      6'd16:   g = 14'b10111101_000000;
      6'd17:   g = 14'b01101111_000000;
      6'd18:   g = 14'b10010000_010010;
      6'd19:   g = 14'b01111000_000000;
      6'd20:   g = 14'b00001110_001100;
      6'd21:   g = 14'b00011100_000000;
      6'd22:   g = 14'b01101100_101000;
      6'd23:   g = 14'b01101100_100100;
      6'd24:   g = 14'b11111100_000000;
      6'd25:   g = 14'b11001111_000000;
      6'd26:   g = 14'b11111100_000100;
      6'd27:   g = 14'b11001111_000100;
      6'd28:   g = 14'b10110111_000000;
      6'd29:   g = 14'b10000000_010010;
      6'd30:   g = 14'b01111100_000000;
      6'd31:   g = 14'b00001100_001001;
      6'd32:   g = 14'b01101100_000101;
      6'd33:   g = 14'b00000000_101101;
      6'd34:   g = 14'b00000000_101010;
      6'd35:   g = 14'b10010000_001001;
      default: g = 14'b00000000_000000;  // space (36) and the blank codes 37-63
    endcase
    return g;
  endfunction

  state_t         state_r;
  logic [DGW-1:0] digit_r;
  logic [DWW-1:0] dwell_cnt_r;
  logic [BKW-1:0] blank_cnt_r;
  logic [FCW-1:0] frame_cnt_r;
  logic [3:0]     offset_r;
  logic [5:0]     buf_r [BUF_DEPTH];

  logic [4:0]     len_s;
  logic [3:0]     offset_eff_s;
  logic [7:0]     sum_s;
  logic [3:0]     idx_s;
  logic           show_blank_s;
  logic           wr_fire_s;
  logic [5:0]     char_s;
  logic [13:0]    glyph_s;
  logic           drive_entry_s;
  logic           frame_end_s;
  logic [3:0]     offset_base_s;
  logic [3:0]     offset_inc_s;
  logic [3:0]     offset_nxt_s;
  logic [FCW-1:0] frame_cnt_nxt_s;

`ifdef SEG14_BLINK_EN
  logic [4:0]     blink_cnt_r;
  logic           blink_phase_r;
`endif

  // Pick the buffer entry for the digit about to be driven.
  always_comb begin
    len_s        = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
    // An offset left beyond a shortened message restarts at 0 on DRIVE entry.
    offset_eff_s = ({1'b0, offset_r} >= len_s) ? 4'd0 : offset_r;
    sum_s        = 8'(offset_eff_s) + 8'(digit_r);
    idx_s        = 4'd0;
    show_blank_s = 1'b1;
    if (len_s == 5'd0) begin
      show_blank_s = 1'b1;
    end else if (!scroll_en) begin
      if (8'(digit_r) < 8'(len_s)) begin
        idx_s        = 4'(digit_r);
        show_blank_s = 1'b0;
      end else begin
        show_blank_s = 1'b1;
      end
    end else begin
      idx_s        = 4'(sum_s % 8'(len_s));
      show_blank_s = 1'b0;
    end
  end

  // Fetch the character, forwarding a write that lands on the same edge as the read.
  always_comb begin
    wr_fire_s = wr_en && wr_ready;
    if (show_blank_s) begin
      char_s = CODE_SPACE;
    end else if (wr_fire_s && (wr_addr == idx_s)) begin
      char_s = wr_data;
    end else begin
      char_s = buf_r[idx_s];
    end
`ifdef SEG14_BLINK_EN
    glyph_s = (blink_phase_r && blink_mask[digit_r]) ? 14'd0 : seg14_glyph(char_s);
`else
    glyph_s = seg14_glyph(char_s);
`endif
  end

  // Frame-end and scroll-offset bookkeeping.
  always_comb begin
    drive_entry_s   = (state_r == ST_DRIVE) && (dwell_cnt_r == '0);
    frame_end_s     = (state_r == ST_DRIVE) && (dwell_cnt_r == DWELL_LAST) &&
                      (digit_r == DIGIT_LAST);
    offset_base_s   = drive_entry_s ? offset_eff_s : offset_r;
    offset_inc_s    = (({1'b0, offset_base_s} + 5'd1) >= len_s) ? 4'd0 :
                      (offset_base_s + 4'd1);
    offset_nxt_s    = offset_base_s;
    frame_cnt_nxt_s = frame_cnt_r;
    if (!scroll_en) begin
      offset_nxt_s    = 4'd0;
      frame_cnt_nxt_s = '0;
    end else if (frame_end_s) begin
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_nxt_s = '0;
        offset_nxt_s    = offset_inc_s;
      end else begin
        frame_cnt_nxt_s = frame_cnt_r + FCW'(1);
        offset_nxt_s    = offset_base_s;
      end
    end else begin
      frame_cnt_nxt_s = frame_cnt_r;
      offset_nxt_s    = offset_base_s;
    end
  end

  // Scan FSM: sequences BLANK/DRIVE, registers the display outputs and owns the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_BLANK;
      digit_r     <= '0;
      dwell_cnt_r <= '0;
      blank_cnt_r <= '0;
      frame_cnt_r <= '0;
      offset_r    <= 4'd0;
      sel         <= '0;
      segm        <= 14'd0;
      frame_done  <= 1'b0;
      wr_ready    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_r[i] <= CODE_SPACE;
      end
    end else begin
      if (wr_fire_s) begin
        buf_r[wr_addr] <= wr_data;
      end
      frame_cnt_r <= frame_cnt_nxt_s;
      offset_r    <= offset_nxt_s;
      frame_done  <= frame_end_s;
      case (state_r)
        ST_BLANK: begin
          sel      <= '0;
          segm     <= 14'd0;
          wr_ready <= 1'b1;
          if (blank_cnt_r == BLANK_LAST) begin
            blank_cnt_r <= '0;
            state_r     <= ST_DRIVE;
          end else begin
            blank_cnt_r <= blank_cnt_r + BKW'(1);
          end
        end
        ST_DRIVE: begin
          wr_ready <= 1'b0;
          // The buffer is read once, on DRIVE entry. The glyph is then held for the dwell.
          if (drive_entry_s) begin
            sel  <= SEL_ONE << digit_r;
            segm <= glyph_s;
          end
          if (dwell_cnt_r == DWELL_LAST) begin
            dwell_cnt_r <= '0;
            state_r     <= ST_BLANK;
            digit_r     <= (digit_r == DIGIT_LAST) ? '0 : (digit_r + DGW'(1));
          end else begin
            dwell_cnt_r <= dwell_cnt_r + DWW'(1);
          end
        end
        default: begin
          state_r     <= ST_BLANK;
          digit_r     <= '0;
          dwell_cnt_r <= '0;
          blank_cnt_r <= '0;
          sel         <= '0;
          segm        <= 14'd0;
          wr_ready    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEG14_BLINK_EN
  // Blink phase flips once every 32 completed frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_r   <= 5'd0;
      blink_phase_r <= 1'b0;
    end else if (frame_end_s) begin
      blink_cnt_r <= blink_cnt_r + 5'd1;
      if (blink_cnt_r == 5'd31) begin
        blink_phase_r <= ~blink_phase_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg14_scan_sched.sv
// -----------------------------------------------------------------------------
// Self-checking bench for seg14_scan_sched (default build, SCROLL_DIV=2).
// Expected digit frames are pushed to a scoreboard queue from a bench-side
// buffer model. They are popped as each DRIVE entry is observed on sel/segm.
// -----------------------------------------------------------------------------
module tb_seg14_scan_sched;

  localparam int ND = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [5:0]  wr_data = 6'd0;
  logic [4:0]  msg_len = 5'd0;
  logic        scroll_en = 1'b0;
  logic        wr_ready;
  logic        frame_done;
  logic [11:0] sel;
  logic [13:0] segm;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct packed {
    logic [11:0] s;
    logic [13:0] g;
  } exp_t;

  exp_t        sb_q[$];
  int          tb_buf[16];
  logic [11:0] obs_sel[ND];
  logic [13:0] obs_seg[ND];
  int          obs_t[ND];
  int          msg_codes[12] = '{14, 28, 12, 10, 21, 14, 27, 10, 2, 0, 2, 3};  // ESCALERA2023

  seg14_scan_sched #(
    .NUM_DIGITS(12), .BUF_DEPTH(16), .DWELL_CYCLES(4), .BLANK_CYCLES(1), .SCROLL_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .msg_len(msg_len), .scroll_en(scroll_en),
    .sel(sel), .segm(segm), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] ref_glyph(input int code);
    case (code)
      0:       return 14'b11111100001001;
      2:       return 14'b11011011000000;
      3:       return 14'b11110001000000;
      10:      return 14'b11101111000000;
      12:      return 14'b10011100000000;
      14:      return 14'b10011110000000;
      21:      return 14'b00011100000000;
      27:      return 14'b11001111000100;
      28:      return 14'b10110111000000;
      default: return 14'b00000000000000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drive(output logic [11:0] s, output logic [13:0] g, output int t);
    logic [11:0] prev;
    bit got;
    prev = sel;
    got = 1'b0;
    s = 12'd0;
    g = 14'd0;
    t = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      if (sel != 12'd0 && prev == 12'd0) begin
        got = 1'b1;
        s = sel;
        g = segm;
        t = cyc;
      end
      prev = sel;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL drive_timeout: no DRIVE entry within 100 cycles, required one");
    end
  endtask

  task automatic capture_frame();
    for (int i = 0; i < ND; i++) begin
      wait_drive(obs_sel[i], obs_seg[i], obs_t[i]);
    end
  endtask

  task automatic wait_fd();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (frame_done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_done_timeout: no pulse within 200 cycles, required one");
    end
  endtask

  task automatic push_frame(input int off);
    int   len;
    exp_t e;
    len = (msg_len > 5'd16) ? 16 : int'(msg_len);
    for (int i = 0; i < ND; i++) begin
      e.s = 12'd0;
      e.s[i] = 1'b1;
      if (len == 0)        e.g = 14'd0;
      else if (!scroll_en) e.g = (i < len) ? ref_glyph(tb_buf[i]) : 14'd0;
      else                 e.g = ref_glyph(tb_buf[(off + i) % len]);
      sb_q.push_back(e);
    end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [5:0] d);
    bit done;
    done = 1'b0;
    wr_addr = a;
    wr_data = d;
    wr_en = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (wr_ready === 1'b1) begin
        step();
        done = 1'b1;
      end else begin
        step();
      end
    end
    wr_en = 1'b0;
    if (done) begin
      tb_buf[a] = int'(d);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL write_timeout: addr %0d not accepted within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    msg_len = 5'd0;
    scroll_en = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) tb_buf[i] = 36;
    repeat (3) step();
    n_cmp++; if (sel !== 12'd0)       begin n_err++; $display("FAIL rst_sel: got %h want 000", sel); end
    n_cmp++; if (segm !== 14'd0)      begin n_err++; $display("FAIL rst_segm: got %b want 0", segm); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    n_cmp++; if (wr_ready !== 1'b0)   begin n_err++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (sel !== 12'd0)     begin n_err++; $display("FAIL rel_sel: got %h want 000", sel); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rel_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_scan_blank();
    exp_t e;
    int t0;
    push_frame(0);
    capture_frame();
    for (int i = 0; i < ND; i++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (obs_sel[i] !== e.s || obs_seg[i] !== e.g) begin
        n_err++;
        $display("FAIL scan d%0d: got sel=%h segm=%b want sel=%h segm=%b", i, obs_sel[i], obs_seg[i], e.s, e.g);
      end
      if (i > 0) begin
        n_cmp++;
        if (obs_t[i] - obs_t[i-1] !== 5) begin
          n_err++;
          $display("FAIL scan_spacing d%0d: got %0d want 5", i, obs_t[i] - obs_t[i-1]);
        end
      end
    end
    wait_fd();
    t0 = cyc;
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL fd_width: got %b want 0", frame_done); end
    wait_fd();
    n_cmp++; if (cyc - t0 !== 60) begin n_err++; $display("FAIL fd_period: got %0d want 60", cyc - t0); end
  endtask

  task automatic test_write_wait();
    logic [11:0] s;
    logic [13:0] g;
    int t, waited;
    exp_t e;
    wait_drive(s, g, t);
    step();
    wr_addr = 4'd0;
    wr_data = 6'd14;
    wr_en = 1'b1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL wr_drive: got %b want 0", wr_ready); end
    waited = 1;
    for (int i = 0; i < 20 && wr_ready !== 1'b1; i++) begin
      step();
      if (wr_ready !== 1'b1) waited++;
    end
    n_cmp++; if (waited !== 3) begin n_err++; $display("FAIL wr_wait: got %0d want 3", waited); end
    n_cmp++; if (sel !== 12'd0) begin n_err++; $display("FAIL wr_in_blank: got sel=%h want 000", sel); end
    step();
    wr_en = 1'b0;
    tb_buf[0] = 14;
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL wr_after: got %b want 0", wr_ready); end
    msg_len = 5'd1;
    wait_fd();
    push_frame(0);
    capture_frame();
    for (int i = 0; i < ND; i++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (obs_sel[i] !== e.s || obs_seg[i] !== e.g) begin
        n_err++;
        $display("FAIL wr_visible d%0d: got sel=%h segm=%b want sel=%h segm=%b", i, obs_sel[i], obs_seg[i], e.s, e.g);
      end
    end
  endtask

  task automatic test_message();
    exp_t e;
    for (int i = 0; i < 12; i++) host_write(4'(i), 6'(msg_codes[i]));
    msg_len = 5'd12;
    wait_fd();
    push_frame(0);
    capture_frame();
    for (int i = 0; i < ND; i++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (obs_sel[i] !== e.s || obs_seg[i] !== e.g) begin
        n_err++;
        $display("FAIL msg d%0d: got sel=%h segm=%b want sel=%h segm=%b", i, obs_sel[i], obs_seg[i], e.s, e.g);
      end
    end
  endtask

  task automatic test_short_len();
    exp_t e;
    msg_len = 5'd3;
    wait_fd();
    push_frame(0);
    capture_frame();
    for (int i = 0; i < ND; i++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (obs_sel[i] !== e.s || obs_seg[i] !== e.g) begin
        n_err++;
        $display("FAIL short d%0d: got sel=%h segm=%b want sel=%h segm=%b", i, obs_sel[i], obs_seg[i], e.s, e.g);
      end
    end
  endtask

  task automatic test_scroll();
    exp_t e;
    int pulses;
    msg_len = 5'd13;
    wait_fd();
    scroll_en = 1'b1;
    pulses = 0;
    for (int f = 0; f < 28; f++) begin
      push_frame((pulses / 2) % 13);
      capture_frame();
      for (int i = 0; i < ND; i++) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (obs_sel[i] !== e.s || obs_seg[i] !== e.g) begin
          n_err++;
          $display("FAIL scroll p%0d d%0d: got sel=%h segm=%b want sel=%h segm=%b", pulses, i, obs_sel[i], obs_seg[i], e.s, e.g);
        end
      end
      wait_fd();
      pulses++;
    end
    scroll_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] s;
    logic [13:0] g;
    int t;
    exp_t e;
    msg_len = 5'd12;
    s = 12'd0;
    for (int i = 0; i < 30 && s !== 12'h020; i++) wait_drive(s, g, t);
    step();
    n_cmp++; if (sel !== 12'h020) begin n_err++; $display("FAIL mid_pre: got sel=%h want 020", sel); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (sel !== 12'd0)       begin n_err++; $display("FAIL mid_sel: got %h want 000", sel); end
    n_cmp++; if (segm !== 14'd0)      begin n_err++; $display("FAIL mid_segm: got %b want 0", segm); end
    n_cmp++; if (wr_ready !== 1'b0)   begin n_err++; $display("FAIL mid_wr_ready: got %b want 0", wr_ready); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL mid_fd: got %b want 0", frame_done); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) tb_buf[i] = 36;
    step();
    n_cmp++; if (sel !== 12'd0)     begin n_err++; $display("FAIL mid_rel_sel: got %h want 000", sel); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_wr_ready: got %b want 1", wr_ready); end
    push_frame(0);
    capture_frame();
    for (int i = 0; i < ND; i++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (obs_sel[i] !== e.s || obs_seg[i] !== e.g) begin
        n_err++;
        $display("FAIL mid_restart d%0d: got sel=%h segm=%b want sel=%h segm=%b", i, obs_sel[i], obs_seg[i], e.s, e.g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_blank();
    test_write_wait();
    test_message();
    test_short_len();
    test_scroll();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
